// File: rtl/bpu_upd_arb.sv
// bpu_upd_arb -- update arbiter / sequencer for the branch-predictor PC generator.
//
// Merges execute-stage mispredict redirects, decode-stage (BTB-miss) redirects
// and commit-stage reinforce requests into one registered update per cycle.
// Redirects have strict priority (execute over decode); reinforce requests are
// buffered in a small circular FIFO and drained whenever no redirect is taken.
// Decode redirects are ignored for dec_gap cycles after any accepted redirect,
// which suppresses stale decode redirects that follow a flush.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   exe_redir/pc/npc/pat          execute-stage redirect request and payload
//   dec_redir/pc/npc/pat          decode-stage redirect request and payload
//   cmt_valid[nreq]               per-port reinforce request
//   cmt_pc[nreq], cmt_pat[nreq]   committed branch PC / pattern at prediction
//   cmt_ready                     all nreq ports may push this cycle (comb.)
//   redir, reinf                  registered update kind (never both 1)
//   upc, unpc, upat               registered update payload
//
// Handshake: a commit port transfers an entry in a cycle where cmt_valid[i]
// and cmt_ready are both 1 and cmt_pat[i] is a weak state (01/10); entries
// offered while cmt_ready is 0 are dropped, not held. The redirect inputs and
// the update outputs have no back-pressure: one pulse is one request.

module bpu_upd_arb #(
    parameter int nreq    = 2,
    parameter int qdepth  = 4,
    parameter int dec_gap = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exe_redir,
    input  logic [63:0]           exe_pc,
    input  logic [63:0]           exe_npc,
    input  logic [1:0]            exe_pat,
    input  logic                  dec_redir,
    input  logic [63:0]           dec_pc,
    input  logic [63:0]           dec_npc,
    input  logic [1:0]            dec_pat,
    input  logic [nreq-1:0]       cmt_valid,
    input  logic [nreq-1:0][63:0] cmt_pc,
    input  logic [nreq-1:0][1:0]  cmt_pat,
    output logic                  cmt_ready,
    output logic                  redir,
    output logic                  reinf,
    output logic [63:0]           upc,
    output logic [63:0]           unpc,
    output logic [1:0]            upat
);

    localparam int aw = (qdepth > 1) ? $clog2(qdepth) : 1;
    localparam int cw = $clog2(qdepth) + 1;

    // Queue storage and pointers
    logic [63:0]   q_pc  [qdepth];
    logic [1:0]    q_pat [qdepth];
    logic [aw-1:0] head;
    logic [aw-1:0] tail;
    logic [cw-1:0] count;
    logic [3:0]    gap_cnt;

    // Combinational control
    logic          take_exe;
    logic          take_dec;
    logic          take_redir;
    logic          pop;
    logic [cw-1:0] free_slots;
    logic [cw-1:0] pcnt;
    logic [nreq-1:0] wr_en;
    logic [aw-1:0] wr_idx [nreq];

    // Next values of the registered update
    logic          redir_next;
    logic          reinf_next;
    logic [63:0]   upc_next;
    logic [63:0]   unpc_next;
    logic [1:0]    upat_next;

    assign free_slots = cw'(qdepth) - count;
    assign cmt_ready  = (free_slots >= cw'(nreq));

    assign take_exe   = exe_redir;
    assign take_dec   = dec_redir && !exe_redir && (gap_cnt == 4'd0);
    assign take_redir = take_exe || take_dec;
    // Pop only sees the registered count: a same-cycle push into an empty
    // queue cannot be bypassed to the output.
    assign pop        = !take_redir && (count != '0);

    // Filtered pushes land in consecutive tail slots in port order.
    always_comb begin
        pcnt = '0;
        for (int i = 0; i < nreq; i++) begin
            wr_en[i]  = cmt_ready && cmt_valid[i] &&
                        ((cmt_pat[i] == 2'b01) || (cmt_pat[i] == 2'b10));
            wr_idx[i] = tail + pcnt[aw-1:0];
            if (wr_en[i]) begin
                pcnt = pcnt + cw'(1);
            end
        end
    end

    always_comb begin
        redir_next = 1'b0;
        reinf_next = 1'b0;
        upc_next   = '0;
        unpc_next  = '0;
        upat_next  = '0;
        if (take_exe) begin
            redir_next = 1'b1;
            upc_next   = exe_pc;
            unpc_next  = exe_npc;
            upat_next  = exe_pat;
        end else if (take_dec) begin
            redir_next = 1'b1;
            upc_next   = dec_pc;
            unpc_next  = dec_npc;
            upat_next  = dec_pat;
        end else if (pop) begin
            reinf_next = 1'b1;
            upc_next   = q_pc[head];
            upat_next  = q_pat[head];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            gap_cnt <= 4'd0;
            redir   <= 1'b0;
            reinf   <= 1'b0;
            upc     <= '0;
            unpc    <= '0;
            upat    <= '0;
        end else begin
            head  <= head + aw'(pop);
            tail  <= tail + pcnt[aw-1:0];
            count <= count + pcnt - cw'(pop);
            if (take_redir) begin
                gap_cnt <= 4'(dec_gap);
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
            redir <= redir_next;
            reinf <= reinf_next;
            upc   <= upc_next;
            unpc  <= unpc_next;
            upat  <= upat_next;
        end
    end

    // Payload storage needs no reset: validity is carried by count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < nreq; i++) begin
            if (!rst && wr_en[i]) begin
                q_pc[wr_idx[i]]  <= cmt_pc[i];
                q_pat[wr_idx[i]] <= cmt_pat[i];
            end
        end
    end

endmodule

// File: tb/tb_bpu_upd_arb.sv
// Directed testbench for bpu_upd_arb (nreq=2, qdepth=4, dec_gap=3).
// Inputs are driven 1 time unit after a rising edge; after the next rising
// edge (+1) the registered outputs show the result of that cycle's inputs.

module tb_bpu_upd_arb;

  logic             clk;
  logic             rst;
  logic             exe_redir;
  logic [63:0]      exe_pc;
  logic [63:0]      exe_npc;
  logic [1:0]       exe_pat;
  logic             dec_redir;
  logic [63:0]      dec_pc;
  logic [63:0]      dec_npc;
  logic [1:0]       dec_pat;
  logic [1:0]       cmt_valid;
  logic [1:0][63:0] cmt_pc;
  logic [1:0][1:0]  cmt_pat;
  logic             cmt_ready;
  logic             redir;
  logic             reinf;
  logic [63:0]      upc;
  logic [63:0]      unpc;
  logic [1:0]       upat;

  int n_tests;
  int n_fail;
  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;

  bpu_upd_arb #(.nreq(2), .qdepth(4), .dec_gap(3)) dut (
    .clk(clk), .rst(rst),
    .exe_redir(exe_redir), .exe_pc(exe_pc), .exe_npc(exe_npc), .exe_pat(exe_pat),
    .dec_redir(dec_redir), .dec_pc(dec_pc), .dec_npc(dec_npc), .dec_pat(dec_pat),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_pat(cmt_pat),
    .cmt_ready(cmt_ready),
    .redir(redir), .reinf(reinf), .upc(upc), .unpc(unpc), .upat(upat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    exe_redir = 1'b0; exe_pc = '0; exe_npc = '0; exe_pat = '0;
    dec_redir = 1'b0; dec_pc = '0; dec_npc = '0; dec_pat = '0;
    cmt_valid = '0; cmt_pc = '0; cmt_pat = '0;
  endtask

  task automatic drive_exe(input logic [63:0] pc, input logic [63:0] npc, input logic [1:0] pat);
    exe_redir = 1'b1; exe_pc = pc; exe_npc = npc; exe_pat = pat;
  endtask

  task automatic drive_dec(input logic [63:0] pc, input logic [63:0] npc, input logic [1:0] pat);
    dec_redir = 1'b1; dec_pc = pc; dec_npc = npc; dec_pat = pat;
  endtask

  task automatic drive_cmt(input logic [1:0] v, input logic [63:0] pc0, input logic [1:0] pat0,
                           input logic [63:0] pc1, input logic [1:0] pat1);
    cmt_valid = v;
    cmt_pc[0] = pc0; cmt_pat[0] = pat0;
    cmt_pc[1] = pc1; cmt_pat[1] = pat1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if ({redir, reinf, upc, unpc, upat} !== '0) begin
      $display("FAIL reset_outputs: got redir=%b reinf=%b upc=%h unpc=%h upat=%b, expected all 0",
               redir, reinf, upc, unpc, upat);
      n_fail++;
    end
    n_tests++;
    if (cmt_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b expected 1", cmt_ready);
      n_fail++;
    end
    tick();
    n_tests++;
    if ({redir, reinf, upc, unpc, upat} !== '0) begin
      $display("FAIL idle_outputs: got redir=%b reinf=%b upc=%h, expected all 0", redir, reinf, upc);
      n_fail++;
    end
  endtask

  task automatic test_exe_redir();
    drive_exe(64'h8000_0010, 64'h8000_0100, 2'b01);
    tick();
    clear_inputs();
    n_tests++;
    if (redir !== 1'b1 || reinf !== 1'b0 || upc !== 64'h8000_0010 ||
        unpc !== 64'h8000_0100 || upat !== 2'b01) begin
      $display("FAIL exe_redir: got redir=%b reinf=%b upc=%h unpc=%h upat=%b, expected 1 0 8000_0010 8000_0100 01",
               redir, reinf, upc, unpc, upat);
      n_fail++;
    end
    tick();
    n_tests++;
    if (redir !== 1'b0 || upc !== 64'h0 || unpc !== 64'h0 || upat !== 2'b00) begin
      $display("FAIL exe_redir_one_cycle: got redir=%b upc=%h unpc=%h upat=%b, expected 0 0 0 00",
               redir, upc, unpc, upat);
      n_fail++;
    end
    // let the decode gap expire
    repeat (3) tick();
  endtask

  task automatic test_dec_gap();
    drive_exe(64'h1000, 64'h2000, 2'b10);
    drive_dec(64'h3000, 64'h4000, 2'b01);
    tick();
    exe_redir = 1'b0;
    n_tests++;
    if (redir !== 1'b1 || upc !== 64'h1000 || unpc !== 64'h2000 || upat !== 2'b10) begin
      $display("FAIL exe_priority: got upc=%h unpc=%h upat=%b, expected 1000 2000 10", upc, unpc, upat);
      n_fail++;
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_tests++;
      if (redir !== 1'b0) begin
        $display("FAIL dec_gap_block_%0d: got redir=%b expected 0", k, redir);
        n_fail++;
      end
    end
    tick();
    clear_inputs();
    n_tests++;
    if (redir !== 1'b1 || upc !== 64'h3000 || unpc !== 64'h4000 || upat !== 2'b01) begin
      $display("FAIL dec_after_gap: got redir=%b upc=%h unpc=%h upat=%b, expected 1 3000 4000 01",
               redir, upc, unpc, upat);
      n_fail++;
    end
    repeat (4) tick();
  endtask

  task automatic test_filter();
    drive_cmt(2'b11, 64'h100, 2'b10, 64'h200, 2'b11);
    tick();
    clear_inputs();
    n_tests++;
    if (reinf !== 1'b0) begin
      $display("FAIL filter_no_bypass: got reinf=%b expected 0", reinf);
      n_fail++;
    end
    tick();
    n_tests++;
    if (reinf !== 1'b1 || redir !== 1'b0 || upc !== 64'h100 || upat !== 2'b10 || unpc !== 64'h0) begin
      $display("FAIL filter_reinf: got reinf=%b redir=%b upc=%h upat=%b unpc=%h, expected 1 0 100 10 0",
               reinf, redir, upc, upat, unpc);
      n_fail++;
    end
    tick();
    n_tests++;
    if (reinf !== 1'b0) begin
      $display("FAIL filter_single: got reinf=%b expected 0 (pat 11 must be dropped)", reinf);
      n_fail++;
    end
  endtask

  // Queue head/tail sit at slot 1 here, so the fill wraps the pointers.
  task automatic test_fill_drain();
    drive_exe(64'h50, 64'h60, 2'b01);
    drive_cmt(2'b11, 64'h1000, 2'b01, 64'h1008, 2'b01);
    exp_q.push_back(64'h1000); exp_q.push_back(64'h1008);
    tick();
    n_tests++;
    if (cmt_ready !== 1'b1) begin
      $display("FAIL ready_half: got %b expected 1", cmt_ready);
      n_fail++;
    end
    drive_cmt(2'b11, 64'h1010, 2'b10, 64'h1018, 2'b01);
    exp_q.push_back(64'h1010); exp_q.push_back(64'h1018);
    tick();
    n_tests++;
    if (cmt_ready !== 1'b0) begin
      $display("FAIL ready_full: got %b expected 0", cmt_ready);
      n_fail++;
    end
    // push offered while full must be ignored
    drive_cmt(2'b11, 64'hdead, 2'b01, 64'hbeef, 2'b10);
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_pc = exp_q.pop_front();
      n_tests++;
      if (reinf !== 1'b1 || upc !== exp_pc) begin
        $display("FAIL drain_%0d: got reinf=%b upc=%h expected 1 %h", k, reinf, upc, exp_pc);
        n_fail++;
      end
    end
    tick();
    n_tests++;
    if (reinf !== 1'b0 || cmt_ready !== 1'b1) begin
      $display("FAIL drain_empty: got reinf=%b ready=%b expected 0 1", reinf, cmt_ready);
      n_fail++;
    end
  endtask

  task automatic test_redir_during_drain();
    drive_exe(64'h70, 64'h80, 2'b10);
    drive_cmt(2'b11, 64'h2000, 2'b01, 64'h2008, 2'b10);
    exp_q.push_back(64'h2000); exp_q.push_back(64'h2008);
    tick();
    drive_cmt(2'b01, 64'h2010, 2'b01, 64'h0, 2'b00);
    exp_q.push_back(64'h2010);
    tick();
    clear_inputs();
    tick();
    exp_pc = exp_q.pop_front();
    n_tests++;
    if (reinf !== 1'b1 || upc !== exp_pc) begin
      $display("FAIL mid_drain_first: got reinf=%b upc=%h expected 1 %h", reinf, upc, exp_pc);
      n_fail++;
    end
    drive_exe(64'h9000, 64'h9100, 2'b01);
    tick();
    clear_inputs();
    n_tests++;
    if (redir !== 1'b1 || reinf !== 1'b0 || upc !== 64'h9000 || unpc !== 64'h9100) begin
      $display("FAIL mid_drain_redir: got redir=%b reinf=%b upc=%h unpc=%h expected 1 0 9000 9100",
               redir, reinf, upc, unpc);
      n_fail++;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_pc = exp_q.pop_front();
      n_tests++;
      if (reinf !== 1'b1 || redir !== 1'b0 || upc !== exp_pc) begin
        $display("FAIL mid_drain_resume_%0d: got reinf=%b upc=%h expected 1 %h", k, reinf, upc, exp_pc);
        n_fail++;
      end
    end
    tick();
    n_tests++;
    if (reinf !== 1'b0) begin
      $display("FAIL mid_drain_end: got reinf=%b expected 0", reinf);
      n_fail++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_drain();
    drive_exe(64'ha0, 64'hb0, 2'b01);
    drive_cmt(2'b11, 64'h3000, 2'b01, 64'h3008, 2'b01);
    tick();
    drive_cmt(2'b01, 64'h3010, 2'b10, 64'h0, 2'b00);
    tick();
    clear_inputs();
    // reset cycle with a decode redirect present: must be ignored
    rst = 1'b1;
    drive_dec(64'h5000, 64'h5100, 2'b10);
    tick();
    rst = 1'b0;
    n_tests++;
    if ({redir, reinf, upc, unpc, upat} !== '0 || cmt_ready !== 1'b1) begin
      $display("FAIL reset_mid: got redir=%b reinf=%b upc=%h ready=%b expected 0 0 0 1",
               redir, reinf, upc, cmt_ready);
      n_fail++;
    end
    tick();
    clear_inputs();
    n_tests++;
    if (redir !== 1'b1 || unpc !== 64'h5100 || upat !== 2'b10) begin
      $display("FAIL dec_after_reset: got redir=%b unpc=%h upat=%b expected 1 5100 10", redir, unpc, upat);
      n_fail++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (reinf !== 1'b0) begin
        $display("FAIL reset_flush_%0d: got reinf=%b expected 0", k, reinf);
        n_fail++;
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_exe_redir();
    test_dec_gap();
    test_filter();
    test_fill_drain();
    test_redir_during_drain();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
